// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for a 5-stage RISC-V pipeline: operand forwarding,
// load-use stalls, branch flushes and a data-memory wait FSM. Optional macro: PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       ResultSrcE0,
  input  logic       PCSrcE,
  input  logic       MemAccessM,
  input  logic       dmem_ack,
  output logic       dmem_req,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic       mem_err
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] mem_wait_cycles
`endif
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] CNT_LAST = TW'(MEM_TIMEOUT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mem_state_t;

  mem_state_t    state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          mem_err_q, mem_err_d;

  logic          lw_stall;
  logic          mem_stall;
  logic          timeout_hit;

  // Forwarding: index 0 is the rs1 path, index 1 the rs2 path; M outranks W.
  logic [1:0][4:0] rs_e;
  logic [1:0][1:0] fwd_sel;

  assign rs_e = {Rs2E, Rs1E};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_sel[gi] =
          reset                                                   ? 2'b00 :
          (RegWriteM && (RdM == rs_e[gi]) && (rs_e[gi] != 5'd0))  ? 2'b10 :
          (RegWriteW && (RdW == rs_e[gi]) && (rs_e[gi] != 5'd0))  ? 2'b01 :
                                                                    2'b00;
    end
  endgenerate

  assign ForwardAE = fwd_sel[0];
  assign ForwardBE = fwd_sel[1];

  assign lw_stall = ~reset & ResultSrcE0 & (RdE != 5'd0) &
                    ((Rs1D == RdE) | (Rs2D == RdE));

  // An expired wait is treated like an ack so the pipeline is released.
  assign timeout_hit = (state_q == S_WAIT) & MemAccessM & ~dmem_ack & (cnt_q == CNT_LAST);
  assign mem_stall   = ~reset & MemAccessM & ~dmem_ack & ~timeout_hit;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_err_d = mem_err_q;
    case (state_q)
      S_IDLE: begin
        if (MemAccessM && !dmem_ack) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (!MemAccessM || dmem_ack) begin
          state_d = S_IDLE;
        end else if (timeout_hit) begin
          state_d   = S_IDLE;
          mem_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  // A frozen E stage must keep its contents, so flushes wait for the stall to clear.
  assign dmem_req = MemAccessM & ~reset;
  assign StallF   = lw_stall | mem_stall;
  assign StallD   = lw_stall | mem_stall;
  assign StallE   = mem_stall;
  assign StallM   = mem_stall;
  assign FlushW   = mem_stall;
  assign FlushD   = ~reset & PCSrcE & ~mem_stall;
  assign FlushE   = ~reset & (lw_stall | PCSrcE) & ~mem_stall;
  assign mem_err  = mem_err_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic [CNT_W-1:0] mem_wait_cycles_q, mem_wait_cycles_d;

  always_comb begin
    stall_cycles_d    = stall_cycles_q + (StallD ? CNT_W'(1) : '0);
    flush_count_d     = flush_count_q + (FlushE ? CNT_W'(1) : '0);
    mem_wait_cycles_d = mem_wait_cycles_q + (mem_stall ? CNT_W'(1) : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q    <= '0;
      flush_count_q     <= '0;
      mem_wait_cycles_q <= '0;
    end else begin
      stall_cycles_q    <= stall_cycles_d;
      flush_count_q     <= flush_count_d;
      mem_wait_cycles_q <= mem_wait_cycles_d;
    end
  end

  assign stall_cycles    = stall_cycles_q;
  assign flush_count     = flush_count_q;
  assign mem_wait_cycles = mem_wait_cycles_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4).
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemAccessM, dmem_ack;
  logic       dmem_req;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
`ifdef PERF_CNT_EN
  logic [7:0] stall_cycles, flush_count, mem_wait_cycles;
`endif

  int checks = 0;
  int errors = 0;

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,dmem_req}
  logic [7:0] ctl;
  logic [3:0] fwd;
  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, dmem_req};
  assign fwd = {ForwardAE, ForwardBE};

  localparam logic [7:0] C_IDLE = 8'b0000_0000;
  localparam logic [7:0] C_REQ  = 8'b0000_0001;
  localparam logic [7:0] C_MEM  = 8'b1111_0011;
  localparam logic [7:0] C_LW   = 8'b1100_0100;
  localparam logic [7:0] C_BR   = 8'b0000_1100;
  localparam logic [7:0] C_LWBR = 8'b1100_1100;
  localparam logic [7:0] C_REL  = 8'b0000_1101;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .MemAccessM(MemAccessM), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .mem_err(mem_err)
`ifdef PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count),
    .mem_wait_cycles(mem_wait_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0; PCSrcE = 0;
    MemAccessM = 0; dmem_ack = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    reset = 1'b1;
    // Reset overrides every output regardless of inputs
    RdM = 5; RegWriteM = 1; Rs1E = 5; Rs2E = 5; MemAccessM = 1; PCSrcE = 1;
    ResultSrcE0 = 1; RdE = 7; Rs1D = 7;
    #1;
    chk("rst_ctl", ctl, C_IDLE);
    chk("rst_fwd", fwd, 4'b0000);
    tick(); tick();
    chk("rst_err", mem_err, 0);
    reset = 1'b0;
    clear_inputs();
    #1;

    // Forwarding
    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 0; #1;
    chk("fwd_m_pri", fwd, 4'b1000);
    RegWriteM = 0; #1;
    chk("fwd_w", fwd, 4'b0100);
    RegWriteM = 1; Rs2E = 5; #1;
    chk("fwd_both_m", fwd, 4'b1010);
    Rs1E = 0; RdM = 0; RdW = 0; Rs2E = 0; #1;
    chk("fwd_x0", fwd, 4'b0000);
    RdM = 3; RdW = 9; Rs1E = 9; Rs2E = 3; #1;
    chk("fwd_split", fwd, 4'b0110);
    clear_inputs(); #1;

    // Load-use
    ResultSrcE0 = 1; RdE = 7; Rs2D = 7; #1;
    chk("lw_stall", ctl, C_LW);
    tick();
    ResultSrcE0 = 0; #1;
    chk("lw_released", ctl, C_IDLE);
    ResultSrcE0 = 1; RdE = 0; Rs2D = 0; #1;
    chk("lw_rd0", ctl, C_IDLE);
    RdE = 4; Rs1D = 4; PCSrcE = 1; #1;
    chk("lw_and_br", ctl, C_LWBR);
    ResultSrcE0 = 0; #1;
    chk("branch", ctl, C_BR);
    clear_inputs();
    tick();

    // Zero-wait ack
    MemAccessM = 1; dmem_ack = 1; #1;
    chk("mem_zero_wait", ctl, C_REQ);
    tick();

    // Ack after 3 low cycles: 3 stall cycles, 4 request cycles
    dmem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      #1; chk($sformatf("mem_wait%0d", i), ctl, C_MEM);
      tick();
    end
    dmem_ack = 1; #1;
    chk("mem_ack", ctl, C_REQ);
    tick();
    clear_inputs(); #1;
    chk("mem_done", ctl, C_IDLE);
    chk("mem_ok_err", mem_err, 0);
    tick();

    // Timeout: 4 stall cycles, then release and sticky error
    MemAccessM = 1;
    for (int i = 0; i < 4; i++) begin
      #1; chk($sformatf("to_stall%0d", i), ctl, C_MEM);
      tick();
    end
    #1;
    chk("to_release", ctl, C_REQ);
    chk("to_err_pre", mem_err, 0);
    tick();
    MemAccessM = 0; #1;
    chk("to_err_set", mem_err, 1);
    chk("to_idle", ctl, C_IDLE);
    tick(); tick();
    chk("to_err_sticky", mem_err, 1);

    // Branch during a 2-cycle memory stall
    MemAccessM = 1; PCSrcE = 1;
    for (int i = 0; i < 2; i++) begin
      #1; chk($sformatf("br_frozen%0d", i), ctl, C_MEM);
      tick();
    end
    dmem_ack = 1; #1;
    chk("br_release", ctl, C_REL);
    tick();
    clear_inputs();
    tick();

    // Reset in the second WAIT cycle
    MemAccessM = 1;
    tick(); tick();
    reset = 1; RdM = 5; RegWriteM = 1; Rs1E = 5; #1;
    chk("rst_wait_ctl", ctl, C_IDLE);
    chk("rst_wait_fwd", fwd, 4'b0000);
    tick();
    reset = 0; clear_inputs(); #1;
    chk("rst_wait_err", mem_err, 0);
`ifdef PERF_CNT_EN
    chk("perf_rst_stall", stall_cycles, 0);
    chk("perf_rst_flush", flush_count, 0);
    chk("perf_rst_mem", mem_wait_cycles, 0);
`endif
    tick();

    // Abandoned access: no error
    MemAccessM = 1;
    tick(); tick();
    MemAccessM = 0; #1;
    chk("abandon_ctl", ctl, C_IDLE);
    tick();
    chk("abandon_err", mem_err, 0);

    // Fresh request after abandon must see a full timeout window
    MemAccessM = 1;
    for (int i = 0; i < 4; i++) begin
      #1; chk($sformatf("re_stall%0d", i), ctl, C_MEM);
      tick();
    end
    #1;
    chk("re_release", ctl, C_REQ);
    tick();
    MemAccessM = 0; PCSrcE = 1; #1;
    chk("re_err", mem_err, 1);
    tick();
    PCSrcE = 0;
`ifdef PERF_CNT_EN
    chk("perf_stall", stall_cycles, 6);
    chk("perf_flush", flush_count, 1);
    chk("perf_mem", mem_wait_cycles, 6);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage RISC-V pipeline (F/D/E/M/W).
- Generates ALU operand forwarding selects, load-use stalls and branch/jump flushes.
- Runs a data-memory request/acknowledge FSM that freezes the pipeline while a lw/sw in M waits on a multi-cycle data memory, with a timeout abort.
- Sits beside the datapath and drives the stall and flush inputs of every pipeline register.

Parameters:
- MEM_TIMEOUT, 15, max cycles in WAIT before abort (>=1).
- CNT_W, 32, width of performance counters (only with PERF_CNT_EN).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- Rs1D, Rs2D  in  5  source regs of D-stage instruction
- Rs1E, Rs2E  in  5  source regs of E-stage instruction
- RdE, RdM, RdW  in  5  destination regs in E, M, W
- RegWriteM, RegWriteW  in  1  register write enables in M, W
- ResultSrcE0  in  1  bit 0 of ResultSrcE; 1 = load in E
- PCSrcE  in  1  taken branch or jump resolved in E
- MemAccessM  in  1  lw or sw occupying M
- dmem_ack  in  1  data memory completes the access this cycle
- dmem_req  out  1  data memory request
- ForwardAE, ForwardBE  out  2  00 = regfile, 10 = ALUResultM, 01 = ResultW
- StallF, StallD, StallE, StallM  out  1  hold pipeline register
- FlushD, FlushE, FlushW  out  1  bubble pipeline register
- mem_err  out  1  sticky; a memory access timed out

Behaviour:
Forwarding (combinational):
- ForwardAE = 10 if RegWriteM & RdM==Rs1E & Rs1E!=0.
- Otherwise 01 if RegWriteW & RdW==Rs1E & Rs1E!=0.
- Otherwise 00. M has priority over W.
- ForwardBE is identical, using Rs2E.

Load-use detection:
- lwStall = ResultSrcE0 & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).

Memory FSM, states IDLE and WAIT:
- dmem_req = MemAccessM & ~reset in both states.
- IDLE: if MemAccessM & ~dmem_ack, go to WAIT and clear the timeout counter to 0. If dmem_ack arrives in the same cycle, there is no stall and the state stays IDLE.
- WAIT, on dmem_ack: go to IDLE; the stall drops that cycle, so the instruction advances at the next edge.
- WAIT, without ack: the counter increments each cycle.
- WAIT, counter == MEM_TIMEOUT-1 without ack: set mem_err, treat the cycle as an ack (stall drops), go to IDLE.
- WAIT, MemAccessM falls without ack (abnormal): go to IDLE; no error is raised.
- Counter width is $clog2(MEM_TIMEOUT+1).

memStall:
- memStall = MemAccessM & ~dmem_ack & ~timeout_hit.
- A zero-wait ack gives 0 stall cycles. An ack N cycles after first request gives exactly N stall cycles.

Stall and flush outputs:
- StallF = StallD = lwStall | memStall.
- StallE = StallM = memStall.
- FlushW = memStall; a bubble enters W while M is frozen.
- FlushD = PCSrcE & ~memStall.
- FlushE = (lwStall | PCSrcE) & ~memStall.
- Frozen E must not flush. A branch in E during memStall takes effect in the first cycle after the stall releases.
- lwStall and PCSrcE in the same cycle: FlushD=1, FlushE=1, StallF=StallD=1. Because the PC mux honours PCSrcE, StallF must not block the branch target; the datapath gives PCSrcE priority over StallF.

Reset:
- reset=1 forces state IDLE, counter 0, mem_err 0.
- It also forces all Stall*/Flush*/dmem_req outputs to 0 and Forward* to 00, regardless of inputs.
- Reset during WAIT drops dmem_req the same cycle and returns to IDLE at the edge.
- mem_err is cleared only by reset.

Optional Feature:
PERF_CNT_EN
- Defined: adds outputs stall_cycles [CNT_W-1:0], flush_count [CNT_W-1:0] and mem_wait_cycles [CNT_W-1:0].
- stall_cycles counts cycles with StallD=1.
- flush_count counts cycles with FlushE=1.
- mem_wait_cycles counts cycles with memStall=1.
- All counters are synchronously reset to 0 and wrap modulo 2^CNT_W.
- Undefined: the counter ports and logic are absent; all other behaviour is identical.

Test Plan:
1. RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5, Rs2E=0 -> ForwardAE=10, ForwardBE=00. Same with RegWriteM=0 -> ForwardAE=01.
2. ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle; FlushD=0. Same with RdE=0 -> no stall.
3. MemAccessM=1, dmem_ack low 3 cycles then high -> dmem_req high 4 cycles; StallF/D/E/M and FlushW high exactly 3 cycles; FSM back in IDLE; mem_err=0.
4. MEM_TIMEOUT=4, MemAccessM=1, dmem_ack never -> stall high 4 cycles (IDLE cycle plus 3 WAIT), then drops; mem_err=1 and stays 1 until reset.
5. PCSrcE=1 during a 2-cycle memStall -> FlushD=FlushE=0 during the stall; both 1 in the cycle after release.
6. reset asserted in the 2nd WAIT cycle -> dmem_req and all stalls 0 that cycle; state IDLE, mem_err 0 next cycle. With PERF_CNT_EN, counters read 0 after reset.
